// File: rtl/line_buffer_ctrl.sv
// 3x3 window generator: four 512x8 line buffers in a ring, one line written while three are read.
// Define LINE_BUFFER_CTRL_OVERFLOW_EN to enable the sticky dropped-pixel flag on o_overflow.

module line_buffer_ram #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 8,
  parameter int PTR_W  = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_rd_en,
  output logic [3*DATA_W-1:0]   o_rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr1;
  logic [PTR_W-1:0]  rd_ptr2;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (i_rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Pointer arithmetic wraps at DEPTH, so the last two windows pick up columns 0/1.
  assign rd_ptr1   = rd_ptr + PTR_W'(1);
  assign rd_ptr2   = rd_ptr + PTR_W'(2);
  assign o_rd_data = {mem[rd_ptr], mem[rd_ptr1], mem[rd_ptr2]};
endmodule

module line_buffer_ctrl #(
  parameter int IMAGE_WIDTH = 512
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_valid,
  output logic        o_intr,
  output logic        o_overflow
);
  localparam int DATA_W  = 8;
  localparam int NUM_BUF = 4;
  localparam int COL_W   = 9;
  localparam int FILL_W  = 12;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(4 * IMAGE_WIDTH);
  localparam logic [FILL_W-1:0] FILL_RD  = FILL_W'(3 * IMAGE_WIDTH);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMAGE_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [COL_W-1:0]       wr_col;
  logic [COL_W-1:0]       rd_col;
  logic [1:0]             wr_sel;
  logic [1:0]             rd_sel;
  logic [1:0]             sel_mid;
  logic [1:0]             sel_new;
  logic [FILL_W-1:0]      fill_cnt;
  logic                   accept;
  logic                   rd_active;
  logic                   line_done;
  logic                   intr_q;
  logic                   buf_rst;
  logic [NUM_BUF-1:0]     buf_wr_en;
  logic [NUM_BUF-1:0]     buf_rd_en;
  logic [3*DATA_W-1:0]    buf_rd_data [NUM_BUF];

  assign buf_rst   = !i_rst_n;
  assign accept    = i_pixel_valid && (fill_cnt < FILL_MAX);
  assign rd_active = (state == READ);
  assign line_done = rd_active && (rd_col == COL_LAST);
  assign sel_mid   = rd_sel + 2'd1;
  assign sel_new   = rd_sel + 2'd2;
  assign buf_wr_en = accept ? (NUM_BUF'(1) << wr_sel) : '0;

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
    line_buffer_ram #(
      .DEPTH  (IMAGE_WIDTH),
      .DATA_W (DATA_W),
      .PTR_W  (COL_W)
    ) u_buf (
      .i_clk     (i_clk),
      .i_rst     (buf_rst),
      .i_wr_en   (buf_wr_en[b]),
      .i_wr_data (i_pixel_data),
      .i_rd_en   (buf_rd_en[b]),
      .o_rd_data (buf_rd_data[b])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_col <= '0;
      wr_sel <= '0;
    end else if (accept) begin
      if (wr_col == COL_LAST) begin
        wr_col <= '0;
        wr_sel <= wr_sel + 2'd1;
      end else begin
        wr_col <= wr_col + COL_W'(1);
      end
    end
  end

  // Fill counts pixels held but not yet retired; one pixel retires per read cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_cnt <= '0;
    end else begin
      case ({accept, rd_active})
        2'b10:   fill_cnt <= fill_cnt + FILL_W'(1);
        2'b01:   fill_cnt <= fill_cnt - FILL_W'(1);
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_cnt >= FILL_RD) state_nxt = READ;
      READ:    if (rd_col == COL_LAST)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    buf_rd_en     = '0;
    o_pixel_valid = 1'b0;
    if (state == READ) begin
      o_pixel_valid      = 1'b1;
      buf_rd_en[rd_sel]  = 1'b1;
      buf_rd_en[sel_mid] = 1'b1;
      buf_rd_en[sel_new] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_col <= '0;
      rd_sel <= '0;
      intr_q <= 1'b0;
    end else begin
      intr_q <= line_done;
      if (line_done) begin
        rd_col <= '0;
        rd_sel <= rd_sel + 2'd1;
      end else if (rd_active) begin
        rd_col <= rd_col + COL_W'(1);
      end
    end
  end

  assign o_intr       = intr_q;
  assign o_pixel_data = {buf_rd_data[rd_sel], buf_rd_data[sel_mid], buf_rd_data[sel_new]};

`ifdef LINE_BUFFER_CTRL_OVERFLOW_EN
  logic drop;
  logic overflow_q;

  assign drop = i_pixel_valid && !accept;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl: a line-history model predicts every window and line-done pulse.
module tb_line_buffer_ctrl;
  localparam int W = 512;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_pixel_data = 8'h00;
  logic        i_pixel_valid = 1'b0;
  logic [71:0] o_pixel_data;
  logic        o_pixel_valid;
  logic        o_intr;
  logic        o_overflow;

  line_buffer_ctrl #(.IMAGE_WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pixel_data  (i_pixel_data),
    .i_pixel_valid (i_pixel_valid),
    .o_pixel_data  (o_pixel_data),
    .o_pixel_valid (o_pixel_valid),
    .o_intr        (o_intr),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

`ifdef LINE_BUFFER_CTRL_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  typedef struct {
    logic [71:0] data;
    bit          care;
    bit          last;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] hist [0:8191];
  int         n_pix = 0;
  bit         mon_en = 1'b0;
  bit         intr_exp = 1'b0;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic checkw(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Read k covers lines k, k+1, k+2 and becomes due once line k+2 is complete.
  task automatic push_read(input int k);
    exp_t e;
    for (int c = 0; c < W; c++) begin
      e.data = '0;
      for (int r = 0; r < 3; r++) begin
        for (int j = 0; j < 3; j++) begin
          e.data = {e.data[63:0], ((c + j) < W) ? hist[(k + r) * W + c + j] : 8'h00};
        end
      end
      e.care = (c < W - 2);
      e.last = (c == W - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_accept(input logic [7:0] d);
    hist[n_pix] = d;
    n_pix++;
    if ((n_pix % W) == 0 && n_pix >= 3 * W) push_read(n_pix / W - 3);
  endtask

  task automatic put_pix(input logic [7:0] d, input bit v);
    i_pixel_data  = d;
    i_pixel_valid = v;
    @(posedge i_clk);
    if (v) model_accept(d);
    @(negedge i_clk);
    i_pixel_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || intr_exp) && n < 4000) begin
      @(negedge i_clk);
      n++;
    end
    repeat (2) @(negedge i_clk);
    check1(name, (exp_q.size() == 0 && !intr_exp), 1'b1);
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      if (intr_exp) begin
        check1("intr_pulse", o_intr, 1'b1);
        check1("idle_gap", o_pixel_valid, 1'b0);
        intr_exp = 1'b0;
      end else begin
        check1("intr_quiet", o_intr, 1'b0);
      end
      if (o_pixel_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got valid data %h expected no window", o_pixel_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.care) checkw("window", o_pixel_data, mon_e.data);
          if (mon_e.last) intr_exp = 1'b1;
        end
      end
    end
  end

  initial begin
    int acc;
    int n;
    bit v;

    #1;
    check1("rst_valid", o_pixel_valid, 1'b0);
    check1("rst_intr", o_intr, 1'b0);
    check1("rst_ovf", o_overflow, 1'b0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    // Five constant lines written back to back, reads overlapping writes.
    for (int i = 0; i < 5 * W; i++) begin
      put_pix(8'((i / W + 1) * 8'h11), 1'b1);
      if (i == 3 * W - 1) check1("latency_pre", o_pixel_valid, 1'b0);
      if (i == 3 * W) begin
        check1("latency_rise", o_pixel_valid, 1'b1);
        checkw("first_window", o_pixel_data, 72'h111111_222222_333333);
      end
    end
    drain("drain_const");
    check1("no_drop_const", o_overflow, 1'b0);

    // Random pixels with random gaps.
    acc = 0;
    while (acc < 4 * W) begin
      v = ($urandom_range(0, 9) < 7);
      put_pix(8'($urandom), v);
      if (v) acc++;
    end
    drain("drain_random");
    check1("no_drop_random", o_overflow, 1'b0);

    // One more line starts a read; reset it at column 100.
    for (int i = 0; i < W; i++) put_pix(8'($urandom), 1'b1);
    n = 0;
    while (!o_pixel_valid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check1("read_start", o_pixel_valid, 1'b1);
    repeat (100) @(negedge i_clk);
    check1("mid_read", o_pixel_valid, 1'b1);
    #2;
    mon_en  = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check1("async_rst_valid", o_pixel_valid, 1'b0);
    check1("async_rst_intr", o_intr, 1'b0);
    check1("async_rst_ovf", o_overflow, 1'b0);
    exp_q.delete();
    intr_exp = 1'b0;
    n_pix    = 0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < 3 * W - 1; i++) put_pix(8'($urandom), 1'b1);
    repeat (3) @(negedge i_clk);
    check1("no_window_early", o_pixel_valid, 1'b0);
    put_pix(8'($urandom), 1'b1);
    @(negedge i_clk);
    check1("post_rst_rise", o_pixel_valid, 1'b1);
    drain("drain_post_rst");

    // Full buffer: an offered pixel is dropped.
    mon_en = 1'b0;
    force dut.fill_cnt = 12'd2048;
    i_pixel_data  = 8'hAA;
    i_pixel_valid = 1'b1;
    @(posedge i_clk);
    #1;
    check1("ovf_set", o_overflow, OVF_EXP);
    @(negedge i_clk);
    i_pixel_valid = 1'b0;
    release dut.fill_cnt;
    @(posedge i_clk);
    #1;
    check1("ovf_sticky", o_overflow, OVF_EXP);
    #2;
    i_rst_n = 1'b0;
    #1;
    check1("ovf_rst", o_overflow, 1'b0);
    check1("final_rst_valid", o_pixel_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
